key_schedule: RTL and testbench
===============================

KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: key  in  [64:1]  DES key; DES bit i at key[i], parity bits 8,16..64 included.
REQ-004 SHALL have: key_valid  in  1  key offered this cycle.
REQ-005 SHALL have: key_ready  out  1  block idle, key accepted when key_valid&key_ready.
REQ-006 SHALL have: decrypt  in  1  sampled with key; 1 = produce rounds in decryption order.
REQ-007 SHALL have: cd  out  [56:1]  round value C||D (C at cd[28:1], D at cd[56:29]), direct input of the PC-2 stage.
REQ-008 SHALL have: cd_valid  out  1 / cd_ready  in  1  valid/ready handshake on cd.
REQ-009 SHALL have: round  out  4  current round minus 1 (0 = round 1, 15 = round 16).
REQ-010 SHALL have: done  out  1  one-cycle pulse after round-16 transfer.
REQ-011 SHALL have: parity_err  out  1  key parity flag (see Configuration).

Function
REQ-012 SHALL apply PC-1 per FIPS 46-3 to key at acceptance, discarding bits 8,16..64, giving C0 (28 bits), D0 (28 bits).
REQ-013 SHALL implement states IDLE and ROUND; key_ready = 1 only in IDLE; cd_valid = 1 only in ROUND.
REQ-014 IDLE -> ROUND on key_valid&key_ready; round 1 cd valid the cycle after acceptance.
REQ-015 Shift amounts per encryption round r: 1 for r in {1,2,9,16}, else 2; C and D rotated independently.
REQ-016 Encrypt: round r cd = C0,D0 each rotated left by cumulative shift through r; round 16 equals C0||D0.
REQ-017 Decrypt: round 1 cd = C0||D0; round r (2..16) = previous value rotated right by shift of encryption round 18-r.
REQ-018 cd, round SHALL be held stable while cd_valid=1 and cd_ready=0.
REQ-019 On cd_valid&cd_ready with round<15: next cycle round+1, next cd; one round per cycle at full throughput.
REQ-020 On cd_valid&cd_ready with round=15: next cycle IDLE, done=1, key_ready=1; minimum 17 cycles accept-to-done.
REQ-021 key_valid ignored outside IDLE; key and decrypt sampled only at acceptance.
REQ-022 Rotation SHALL be 28-bit circular, no wrap into the other half.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, key_ready=1 after release, cd_valid=0, done=0, round=0, cd=0, parity_err=0.
REQ-024 Reset mid-operation SHALL abandon the schedule; no done pulse; next key starts from round 1.

Configuration
REQ-025 Macro DES_KEY_PARITY_CHK_EN defined: at acceptance, parity_err registered = 1 if any byte key[8k+8:8k+1] (k=0..7) has even parity; held until next acceptance; schedule proceeds regardless.
REQ-026 Macro undefined: parity_err port present, constant 0, no checker logic.

Verification
REQ-027 Key 133457799BBCDFF1 (hex, DES bit 1 first), decrypt=0, cd_ready=1 -> round 0 C=F0CCAAF rotated = E19955F, D=AAACCF1; round 15 C||D = F0CCAAF||556678F; done 17 cycles after accept; via PC-2 round 0 = 1B02EFFC7072.
REQ-028 Same key, decrypt=1 -> round 0 cd = F0CCAAF||556678F; rounds 0..15 equal encrypt rounds 15..0.
REQ-029 Encrypt, cd_ready low 3 cycles at round 4 -> cd, round stable; round 5 appears cycle after cd_ready returns high; done delayed exactly 3 cycles.
REQ-030 rst_n low during round 7 -> cd_valid=0 immediately; no done; new key afterwards yields correct round 0.
REQ-031 With DES_KEY_PARITY_CHK_EN: key above -> parity_err=0; key[1] flipped -> parity_err=1 while rounds still generated; without macro parity_err=0 always.
REQ-032 key_valid held high during ROUND with different key -> ignored; round sequence unchanged; second key accepted in IDLE.

Source files
------------

// File: rtl/key_schedule.sv
// DES key schedule: PC-1 on an accepted key, then 16 C||D rounds over a valid/ready stream.
// Optional key parity checking is enabled by defining DES_KEY_PARITY_CHK_EN.
module key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [64:1] key,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        decrypt,
    output logic [56:1] cd,
    output logic        cd_valid,
    input  logic        cd_ready,
    output logic [3:0]  round,
    output logic        done,
    output logic        parity_err
);

    typedef enum logic {IDLE, ROUND} state_e;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    state_e      state_q, state_d;
    logic [56:1] cd_q, cd_d;
    logic [3:0]  round_q, round_d;
    logic        dec_q, dec_d;
    logic        done_q, done_d;
    logic [56:1] cd0;
    logic [3:0]  sidx;

    // DES bit 1 sits at index 1, so a DES left rotate moves bits toward index 1.
    function automatic logic [28:1] rot(input logic [28:1] h,
                                        input logic left,
                                        input logic two);
        logic [28:1] r;
        case ({left, two})
            2'b10:   r = {h[1], h[28:2]};
            2'b11:   r = {h[2:1], h[28:3]};
            2'b00:   r = {h[27:1], h[28]};
            default: r = {h[26:1], h[28:27]};
        endcase
        return r;
    endfunction

    function automatic logic single(input logic [3:0] i);
        return (i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15);
    endfunction

    always_comb begin
        cd0 = '0;
        for (int i = 0; i < 56; i++) cd0[i+1] = key[PC1[i]];
    end

    // Decrypt round n+1 undoes encryption round 16-n, i.e. index ~round_q.
    assign sidx = dec_q ? ~round_q : round_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        round_d = round_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    state_d = ROUND;
                    round_d = '0;
                    dec_d   = decrypt;
                    cd_d    = decrypt ? cd0
                            : {rot(cd0[56:29], 1'b1, 1'b0),
                               rot(cd0[28:1], 1'b1, 1'b0)};
                end
            end
            ROUND: begin
                if (cd_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q + 4'd1;
                        cd_d    = {rot(cd_q[56:29], !dec_q, !single(sidx)),
                                   rot(cd_q[28:1], !dec_q, !single(sidx))};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cd_q    <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign cd_valid  = (state_q == ROUND);
    assign cd        = cd_q;
    assign round     = round_q;
    assign done      = done_q;

`ifdef DES_KEY_PARITY_CHK_EN
    logic par_q, par_d;

    // Each key byte must carry odd parity; any even byte flags the key.
    always_comb begin
        par_d = par_q;
        if (state_q == IDLE && key_valid) begin
            par_d = 1'b0;
            for (int k = 0; k < 8; k++)
                if (!(^key[8*k+1 +: 8])) par_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end

    assign parity_err = par_q;
`else
    logic unused_parity_bits;
    assign unused_parity_bits = ^{key[64], key[56], key[48], key[40],
                                  key[32], key[24], key[16], key[8]};
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_key_schedule.sv
// Randomized bench for key_schedule against a DES-numbered reference model.
// Parity expectations follow DES_KEY_PARITY_CHK_EN.
module tb_key_schedule;

    logic        clk;
    logic        rst_n;
    logic [64:1] key;
    logic        key_valid;
    logic        key_ready;
    logic        decrypt;
    logic [56:1] cd;
    logic        cd_valid;
    logic        cd_ready;
    logic [3:0]  round;
    logic        done;
    logic        parity_err;

    int nvec;
    int nbad;

    localparam logic [63:0] KREF = 64'h133457799BBCDFF1;

    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    key_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .decrypt    (decrypt),
        .cd         (cd),
        .cd_valid   (cd_valid),
        .cd_ready   (cd_ready),
        .round      (round),
        .done       (done),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Hex key string has DES bit 1 as its MSB; the port has bit i at key[i].
    function automatic logic [64:1] to_port(input logic [63:0] kd);
        logic [64:1] p;
        for (int i = 1; i <= 64; i++) p[i] = kd[64-i];
        return p;
    endfunction

    function automatic logic [55:0] nat56(input logic [56:1] p);
        logic [55:0] r;
        for (int j = 1; j <= 28; j++) begin
            r[56-j] = p[j];
            r[28-j] = p[28+j];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [56:1] p);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = p[PC2[i]];
        return r;
    endfunction

    function automatic logic [56:1] exp_cd(input logic [63:0] kd,
                                           input bit dec, input int i);
        logic [27:0] c0, d0, c, d;
        logic [55:0] cc, dd;
        logic [56:1] p;
        int s, e;
        for (int j = 1; j <= 28; j++) begin
            c0[28-j] = kd[64-PC1[j-1]];
            d0[28-j] = kd[64-PC1[27+j]];
        end
        e = dec ? 15 - i : i;
        s = 0;
        for (int r = 0; r <= e; r++) s += SH[r];
        cc = {c0, c0};
        dd = {d0, d0};
        c = cc[55-s -: 28];
        d = dd[55-s -: 28];
        for (int j = 1; j <= 28; j++) begin
            p[j]    = c[28-j];
            p[28+j] = d[28-j];
        end
        return p;
    endfunction

    function automatic bit par_exp(input logic [63:0] kd);
        bit r;
        r = 1'b0;
`ifdef DES_KEY_PARITY_CHK_EN
        for (int k = 0; k < 8; k++)
            if ((^kd[8*k +: 8]) == 1'b0) r = 1'b1;
`endif
        return r;
    endfunction

    task automatic start(input logic [63:0] kd, input bit dec);
        @(negedge clk);
        chk("key_ready", key_ready, 1);
        chk("done_pulse", done, 0);
        key       = to_port(kd);
        decrypt   = dec;
        key_valid = 1'b1;
        cd_ready  = 1'b1;
    endtask

    task automatic track(input logic [63:0] kd, input bit dec,
                         input int st_at, input int st_n, input int abort_at,
                         input bit hold, input logic [63:0] kd2, input bit dec2);
        int idx, stl, cyc;
        bit fin;
        idx = 0; stl = 0; cyc = 0; fin = 1'b0;
        @(posedge clk);
        #1;
        if (hold) begin
            key     = to_port(kd2);
            decrypt = dec2;
        end else begin
            key_valid = 1'b0;
        end
        while (!fin && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("parity_err", parity_err, par_exp(kd));
            if (idx == 16) begin
                chk("done", done, 1);
                chk("latency", cyc, 17 + st_n);
                chk("ready_after", key_ready, 1);
                fin = 1'b1;
            end else begin
                chk("cd_valid", cd_valid, 1);
                chk("round", round, idx);
                chk("cd", cd, exp_cd(kd, dec, idx));
                chk("done_low", done, 0);
                if (kd == KREF && !dec && idx == 0) begin
                    chk("c_r0", nat56(cd) >> 28, 28'hE19955F);
                    chk("k1_pc2", pc2(cd), 48'h1B02EFFC7072);
                end
                if (kd == KREF && !dec && idx == 15)
                    chk("cd_r15", nat56(cd), 56'hF0CCAAF556678F);
                if (kd == KREF && dec && idx == 0)
                    chk("dec_r0", nat56(cd), 56'hF0CCAAF556678F);
                if (idx == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_cd_valid", cd_valid, 0);
                    chk("rst_cd", cd, 0);
                    chk("rst_round", round, 0);
                    chk("rst_done", done, 0);
                    chk("rst_ready", key_ready, 1);
                    return;
                end
                if (idx == st_at && stl < st_n) begin
                    cd_ready = 1'b0;
                    stl++;
                end else begin
                    cd_ready = 1'b1;
                    idx++;
                end
            end
        end
        if (!fin) chk("done_timeout", 0, 1);
    endtask

    initial begin
        logic [63:0] kr;
        bit saw;
        int sa, sn;
        bit dr;
        nvec      = 0;
        nbad      = 0;
        rst_n     = 1'b0;
        key       = '0;
        key_valid = 1'b0;
        decrypt   = 1'b0;
        cd_ready  = 1'b1;
        #12;
        chk("reset_cd_valid", cd_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_round", round, 0);
        chk("reset_cd", cd, 0);
        chk("reset_parity", parity_err, 0);
        chk("reset_ready", key_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        start(KREF, 1'b0);
        track(KREF, 1'b0, -1, 0, -1, 1'b0, 64'd0, 1'b0);
        start(KREF, 1'b1);
        track(KREF, 1'b1, -1, 0, -1, 1'b0, 64'd0, 1'b0);
        start(KREF, 1'b0);
        track(KREF, 1'b0, 4, 3, -1, 1'b0, 64'd0, 1'b0);

        start(KREF, 1'b0);
        track(KREF, 1'b0, -1, 0, 7, 1'b0, 64'd0, 1'b0);
        key_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || cd_valid) saw = 1'b1;
        end
        chk("no_done_after_rst", saw, 0);
        start(KREF, 1'b0);
        track(KREF, 1'b0, -1, 0, -1, 1'b0, 64'd0, 1'b0);

        start(KREF ^ 64'h8000000000000000, 1'b0);
        track(KREF ^ 64'h8000000000000000, 1'b0, -1, 0, -1, 1'b0, 64'd0, 1'b0);

        kr = {$urandom, $urandom};
        start(KREF, 1'b0);
        track(KREF, 1'b0, -1, 0, -1, 1'b1, kr, 1'b1);
        track(kr, 1'b1, -1, 0, -1, 1'b0, 64'd0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            kr = {$urandom, $urandom};
            dr = 1'($urandom_range(0, 1));
            sa = $urandom_range(0, 15);
            sn = $urandom_range(0, 3);
            start(kr, dr);
            track(kr, dr, sa, sn, -1, 1'b0, 64'd0, 1'b0);
        end

        @(negedge clk);
        chk("final_idle", key_ready, 1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
